conv_mac_array: RTL

CONV_MAC_ARRAY -- requirements
Module: conv_mac_array

---
 rtl/conv_mac_array.sv | 110 +++++++++++
 1 files changed

// File: rtl/conv_mac_array.sv
// rtl/conv_mac_array.sv - parallel fixed-point MAC lanes sharing one weight per kernel tap
// Optional CONV_RELU_EN: clamp negative lane results to zero before the output register.
module conv_mac_array #(
  parameter int ARRAY_SIZE  = 6,
  parameter int DATA_WIDTH  = 16,
  parameter int FRAC_WIDTH  = 8,
  parameter int KERNEL_SIZE = 3
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             clear,
  input  logic                             i_valid,
  output logic                             i_ready,
  input  logic [ARRAY_SIZE*DATA_WIDTH-1:0] i_pixel_bus,
  input  logic [DATA_WIDTH-1:0]            i_weight,
  output logic                             o_valid,
  input  logic                             o_ready,
  output logic [ARRAY_SIZE*DATA_WIDTH-1:0] o_pixel_bus
);

  localparam int TAPS  = KERNEL_SIZE * KERNEL_SIZE;
  localparam int ACC_W = 2 * DATA_WIDTH + $clog2(TAPS);
  localparam int CNT_W = (TAPS > 1) ? $clog2(TAPS) : 1;
  localparam logic [CNT_W-1:0] LAST_TAP = CNT_W'(TAPS - 1);
  localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W-DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};

  typedef enum logic {ACCUM, HOLD} state_t;

  state_t                            state_q, state_d;
  logic [CNT_W-1:0]                  tap_cnt;
  logic                              accept, last_beat, out_fire;
  logic signed [DATA_WIDTH-1:0]      weight_s;
  logic [ARRAY_SIZE*DATA_WIDTH-1:0]  res_bus;

  assign weight_s  = i_weight;
  assign accept    = i_valid && i_ready;
  assign last_beat = accept && (tap_cnt == LAST_TAP);
  assign out_fire  = o_valid && o_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ACCUM;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    i_ready = 1'b0;
    case (state_q)
      ACCUM: begin
        i_ready = 1'b1;
        if (i_valid && (tap_cnt == LAST_TAP)) state_d = HOLD;
      end
      HOLD: if (o_ready) state_d = ACCUM;
      default: state_d = ACCUM;
    endcase
    if (clear) state_d = ACCUM;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)          tap_cnt <= '0;
    else if (clear)      tap_cnt <= '0;
    else if (last_beat)  tap_cnt <= '0;
    else if (accept)     tap_cnt <= tap_cnt + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)          o_valid <= 1'b0;
    else if (clear)      o_valid <= 1'b0;
    else if (last_beat)  o_valid <= 1'b1;
    else if (out_fire)   o_valid <= 1'b0;
  end

  // The result is formed from the sum including the final beat so it can be
  // registered on the same edge that accepts that beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                   o_pixel_bus <= '0;
    else if (last_beat && !clear) o_pixel_bus <= res_bus;
  end

  for (genvar k = 0; k < ARRAY_SIZE; k++) begin : g_lane
    logic signed [DATA_WIDTH-1:0]   px;
    logic signed [2*DATA_WIDTH-1:0] prod;
    logic signed [ACC_W-1:0]        acc, acc_sum, shifted;
    logic [DATA_WIDTH-1:0]          sat;

    assign px      = i_pixel_bus[(ARRAY_SIZE-k)*DATA_WIDTH-1 -: DATA_WIDTH];
    assign prod    = px * weight_s;
    assign acc_sum = acc + ACC_W'(prod);
    assign shifted = acc_sum >>> FRAC_WIDTH;

    always_comb begin
      if (shifted > SAT_MAX)      sat = SAT_MAX[DATA_WIDTH-1:0];
      else if (shifted < SAT_MIN) sat = SAT_MIN[DATA_WIDTH-1:0];
      else                        sat = shifted[DATA_WIDTH-1:0];
`ifdef CONV_RELU_EN
      if (sat[DATA_WIDTH-1]) sat = '0;
`endif
    end

    assign res_bus[(ARRAY_SIZE-k)*DATA_WIDTH-1 -: DATA_WIDTH] = sat;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                 acc <= '0;
      else if (clear || out_fire) acc <= '0;
      else if (accept)            acc <= acc_sum;
    end
  end

endmodule
